// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU command sequencer.
package alu_seq_pkg;

    localparam int unsigned DATA_W    = 8;
    localparam int unsigned SEL_W     = 3;
    localparam int unsigned DEPTH_DEF = 4;
    localparam int unsigned TAG_W_DEF = 4;

    localparam logic [SEL_W-1:0] SEL_AND = 3'b000;
    localparam logic [SEL_W-1:0] SEL_OR  = 3'b001;
    localparam logic [SEL_W-1:0] SEL_XOR = 3'b010;
    localparam logic [SEL_W-1:0] SEL_ADD = 3'b011;
    localparam logic [SEL_W-1:0] SEL_SUB = 3'b100;

    typedef struct packed {
        logic [SEL_W-1:0]  sel;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } alu_cmd_t;

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Command and result channels of the ALU command sequencer.
// Optional OUT_ZERO wire present only when ALU_SEQ_ZERO_FLAG_EN is defined.
interface alu_cmd_sequencer_if #(
    parameter int unsigned TAG_W = alu_seq_pkg::TAG_W_DEF
);
    import alu_seq_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [SEL_W-1:0]  in_sel;
    logic [DATA_W-1:0] in_a;
    logic [DATA_W-1:0] in_b;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_carry;
    logic [SEL_W-1:0]  out_sel;
    logic [TAG_W-1:0]  out_tag;
`ifdef ALU_SEQ_ZERO_FLAG_EN
    logic              out_zero;

    modport master (
        output in_valid, in_sel, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_data, out_carry, out_sel, out_tag, out_zero
    );
    modport slave (
        input  in_valid, in_sel, in_a, in_b, out_ready,
        output in_ready, out_valid, out_data, out_carry, out_sel, out_tag, out_zero
    );
`else
    modport master (
        output in_valid, in_sel, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_data, out_carry, out_sel, out_tag
    );
    modport slave (
        input  in_valid, in_sel, in_a, in_b, out_ready,
        output in_ready, out_valid, out_data, out_carry, out_sel, out_tag
    );
`endif

endinterface

// File: rtl/alu_8bit.sv
// Combinational 8-bit ALU: AND/OR/XOR/ADD, SUB for opcodes 100..111.
module alu_8bit
    import alu_seq_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [SEL_W-1:0]  sel,
    output logic [DATA_W:0]   o,
    output logic              carry
);

    logic [DATA_W:0] sum;
    logic [DATA_W:0] diff;

    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};

    always_comb begin
        o     = '0;
        carry = 1'b0;
        case (sel)
            SEL_AND: o = {1'b0, a & b};
            SEL_OR:  o = {1'b0, a | b};
            SEL_XOR: o = {1'b0, a ^ b};
            SEL_ADD: begin
                o     = {1'b0, sum[DATA_W-1:0]};
                carry = sum[DATA_W];
            end
            default: begin
                o     = {1'b0, diff[DATA_W-1:0]};
                carry = diff[DATA_W];
            end
        endcase
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Buffers ALU commands in a FIFO and issues one per cycle into a registered result stage.
// Optional zero flag: define ALU_SEQ_ZERO_FLAG_EN.
module alu_cmd_sequencer
    import alu_seq_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEF,
    parameter int unsigned TAG_W = TAG_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    alu_cmd_sequencer_if.slave  bus
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    alu_cmd_t          fifo_mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [TAG_W-1:0]  tag_cnt;

    alu_cmd_t          in_cmd;
    alu_cmd_t          head;
    logic              push;
    logic              pop;
    logic [DATA_W:0]   alu_o;
    logic              alu_carry;
    logic              alu_o_unused;

    assign in_cmd       = '{sel: bus.in_sel, a: bus.in_a, b: bus.in_b};
    assign head         = fifo_mem[rd_ptr];
    assign bus.in_ready = !rst && (count < CNT_W'(DEPTH));
    assign push         = bus.in_valid && bus.in_ready;
    // Pop uses the pre-edge count, so an entry pushed this cycle cannot issue yet.
    assign pop          = (count != '0) && (!bus.out_valid || bus.out_ready);
    assign alu_o_unused = alu_o[DATA_W];

    alu_8bit u_alu (
        .a     (head.a),
        .b     (head.b),
        .sel   (head.sel),
        .o     (alu_o),
        .carry (alu_carry)
    );

    // FIFO storage needs no reset; occupancy tracking qualifies every read.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= in_cmd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            tag_cnt       <= '0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_carry <= 1'b0;
            bus.out_sel   <= '0;
            bus.out_tag   <= '0;
`ifdef ALU_SEQ_ZERO_FLAG_EN
            bus.out_zero  <= 1'b0;
`endif
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
            end

            if (pop) begin
                rd_ptr        <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
                tag_cnt       <= tag_cnt + TAG_W'(1);
                bus.out_valid <= 1'b1;
                bus.out_data  <= alu_o[DATA_W-1:0];
                bus.out_carry <= alu_carry;
                bus.out_sel   <= head.sel;
                bus.out_tag   <= tag_cnt;
`ifdef ALU_SEQ_ZERO_FLAG_EN
                bus.out_zero  <= (alu_o[DATA_W-1:0] == DATA_W'(0));
`endif
            end else if (bus.out_valid && bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end

            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Randomized self-checking bench for alu_cmd_sequencer against a queue-based result model.
module tb_alu_cmd_sequencer;
    import alu_seq_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned TAG_W = 4;

    typedef struct packed {
        logic [7:0]       data;
        logic             carry;
        logic             zero;
        logic [2:0]       sel;
        logic [TAG_W-1:0] tag;
    } res_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_cmd_sequencer_if #(.TAG_W(TAG_W)) bus ();

    alu_cmd_sequencer #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    res_t        exp_q[$];
    int unsigned n_acc;
    int          n_cmp  = 0;
    int          n_fail = 0;

    // Expected result of the idx-th accepted command since reset.
    function automatic res_t ref_result(input logic [2:0] sel, input logic [7:0] a,
                                        input logic [7:0] b, input int unsigned idx);
        res_t r;
        int   s;
        r = '0;
        case (sel)
            3'd0: r.data = a & b;
            3'd1: r.data = a | b;
            3'd2: r.data = a ^ b;
            3'd3: begin
                s       = int'(a) + int'(b);
                r.data  = 8'(s);
                r.carry = (s > 255);
            end
            default: begin
                r.data  = a - b;
                r.carry = (a < b);
            end
        endcase
`ifdef ALU_SEQ_ZERO_FLAG_EN
        r.zero = (r.data == 8'h00);
`endif
        r.sel = sel;
        r.tag = TAG_W'(idx % (1 << TAG_W));
        return r;
    endfunction

    // One clock cycle: drive inputs, observe outputs, update the model.
    task automatic tick(input logic v, input logic [2:0] sel, input logic [7:0] a,
                        input logic [7:0] b, input logic ordy,
                        output logic acc, output logic vld, output logic took,
                        output res_t got, output res_t want, output logic have);
        @(negedge clk);
        bus.in_valid  = v;
        bus.in_sel    = sel;
        bus.in_a      = a;
        bus.in_b      = b;
        bus.out_ready = ordy;
        vld  = bus.out_valid;
        acc  = v && bus.in_ready;
        took = vld && ordy;
        got       = '0;
        got.data  = bus.out_data;
        got.carry = bus.out_carry;
        got.sel   = bus.out_sel;
        got.tag   = bus.out_tag;
`ifdef ALU_SEQ_ZERO_FLAG_EN
        got.zero  = bus.out_zero;
`endif
        want = '0;
        have = 1'b0;
        if (took && exp_q.size() > 0) begin
            want = exp_q.pop_front();
            have = 1'b1;
        end
        if (acc) begin
            exp_q.push_back(ref_result(sel, a, b, n_acc));
            n_acc++;
        end
        @(posedge clk);
    endtask

    task automatic do_reset;
        @(negedge clk);
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        n_acc = 0;
    endtask

    task automatic test_reset;
        res_t got;
        logic acc, vld, took, have;
        res_t want;
        @(negedge clk);
        got       = '0;
        got.data  = bus.out_data;
        got.carry = bus.out_carry;
        got.sel   = bus.out_sel;
        got.tag   = bus.out_tag;
`ifdef ALU_SEQ_ZERO_FLAG_EN
        got.zero  = bus.out_zero;
`endif
        n_cmp++;
        if (bus.out_valid !== 1'b0 || got !== res_t'(0)) begin
            n_fail++;
            $display("FAIL reset_outputs: valid=%b data=%h carry=%b zero=%b sel=%b tag=%0d, required all 0",
                     bus.out_valid, got.data, got.carry, got.zero, got.sel, got.tag);
        end
        n_cmp++;
        if (bus.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b required 0", bus.in_ready);
        end
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        exp_q.delete();
        n_acc = 0;
        #1;
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL release_in_ready: got %b required 1", bus.in_ready);
        end
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 3'd0, 8'd0, 8'd0, 1'b1, acc, vld, took, got, want, have);
            n_cmp++;
            if (vld !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_ignored_handshake: out_valid=%b required 0", vld);
            end
        end
    endtask

    task automatic test_add_carry;
        res_t got, want;
        logic acc, vld, took, have;
        do_reset();
        tick(1'b1, SEL_ADD, 8'hFF, 8'h01, 1'b1, acc, vld, took, got, want, have);
        n_cmp++;
        if (acc !== 1'b1) begin
            n_fail++;
            $display("FAIL add_accept: accepted=%b required 1", acc);
        end
        tick(1'b0, 3'd0, 8'd0, 8'd0, 1'b1, acc, vld, took, got, want, have);
        n_cmp++;
        if (vld !== 1'b0) begin
            n_fail++;
            $display("FAIL add_latency_early: out_valid=%b required 0", vld);
        end
        tick(1'b0, 3'd0, 8'd0, 8'd0, 1'b1, acc, vld, took, got, want, have);
        n_cmp++;
        if (vld !== 1'b1 || !have || got !== want || got.data !== 8'h00 || got.carry !== 1'b1
            || got.sel !== SEL_ADD || got.tag !== TAG_W'(0)) begin
            n_fail++;
            $display("FAIL add_result: valid=%b data=%h carry=%b sel=%b tag=%0d, required valid=1 data=00 carry=1 sel=011 tag=0",
                     vld, got.data, got.carry, got.sel, got.tag);
        end
`ifdef ALU_SEQ_ZERO_FLAG_EN
        n_cmp++;
        if (got.zero !== 1'b1) begin
            n_fail++;
            $display("FAIL add_zero: got %b required 1", got.zero);
        end
`endif
    endtask

    task automatic test_sub;
        logic [2:0] s[6]  = '{3'b100, 3'b100, 3'b111, 3'b111, 3'b101, 3'b110};
        logic [7:0] a[6]  = '{8'h05, 8'h07, 8'h05, 8'h07, 8'h80, 8'h00};
        logic [7:0] b[6]  = '{8'h07, 8'h05, 8'h07, 8'h05, 8'h01, 8'h01};
        logic [7:0] d[6]  = '{8'hFE, 8'h02, 8'hFE, 8'h02, 8'h7F, 8'hFF};
        logic       c[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        res_t got, want;
        logic acc, vld, took, have;
        int k = 0;
        int r = 0;
        do_reset();
        for (int i = 0; i < 12; i++) begin
            if (k < 6) tick(1'b1, s[k], a[k], b[k], 1'b1, acc, vld, took, got, want, have);
            else       tick(1'b0, 3'd0, 8'd0, 8'd0, 1'b1, acc, vld, took, got, want, have);
            if (acc) k++;
            if (took) begin
                n_cmp++;
                if (!have || r >= 6 || got !== want || got.data !== d[r] || got.carry !== c[r]) begin
                    n_fail++;
                    $display("FAIL sub_result[%0d]: data=%h carry=%b sel=%b, required data=%h carry=%b sel=%b",
                             r, got.data, got.carry, got.sel, want.data, want.carry, want.sel);
                end
                r++;
            end
        end
        n_cmp++;
        if (r != 6) begin
            n_fail++;
            $display("FAIL sub_count: got %0d results required 6", r);
        end
    endtask

    task automatic test_back_to_back;
        logic [2:0] s[3] = '{SEL_AND, SEL_OR, SEL_XOR};
        logic [7:0] a[3] = '{8'hF0, 8'hF0, 8'hAA};
        logic [7:0] b[3] = '{8'h3C, 8'h0F, 8'hFF};
        logic [7:0] d[3] = '{8'h30, 8'hFF, 8'h55};
        res_t got, want;
        logic acc, vld, took, have;
        int k = 0;
        int r = 0;
        int first = -1;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            if (k < 3) tick(1'b1, s[k], a[k], b[k], 1'b1, acc, vld, took, got, want, have);
            else       tick(1'b0, 3'd0, 8'd0, 8'd0, 1'b1, acc, vld, took, got, want, have);
            if (acc) k++;
            if (took) begin
                if (first < 0) first = i;
                n_cmp++;
                if (!have || r >= 3 || got !== want || got.data !== d[r] || got.carry !== 1'b0
                    || got.tag !== TAG_W'(r) || i != first + r) begin
                    n_fail++;
                    $display("FAIL b2b_result[%0d]: cycle=%0d data=%h carry=%b tag=%0d, required cycle=%0d data=%h carry=0 tag=%0d",
                             r, i, got.data, got.carry, got.tag, first + r, want.data, r);
                end
                r++;
            end
        end
        n_cmp++;
        if (r != 3) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d results required 3", r);
        end
    endtask

    task automatic test_backpressure;
        res_t got, want;
        logic acc, vld, took, have;
        logic [7:0] held = '0;
        logic seen = 1'b0;
        int n_in = 0;
        int r = 0;
        do_reset();
        for (int i = 0; i < 9; i++) begin
            tick(1'b1, 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 1'b0,
                 acc, vld, took, got, want, have);
            if (acc) n_in++;
            if (vld) begin
                if (!seen) begin
                    held = got.data;
                    seen = 1'b1;
                end else begin
                    n_cmp++;
                    if (got.data !== held) begin
                        n_fail++;
                        $display("FAIL bp_hold: out_data=%h required %h", got.data, held);
                    end
                end
            end
        end
        #1;
        n_cmp++;
        if (n_in != DEPTH + 1 || bus.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_accepts: accepts=%0d in_ready=%b, required accepts=%0d in_ready=0",
                     n_in, bus.in_ready, DEPTH + 1);
        end
        for (int i = 0; i < 12; i++) begin
            tick(1'b0, 3'd0, 8'd0, 8'd0, 1'b1, acc, vld, took, got, want, have);
            if (took) begin
                n_cmp++;
                if (!have || got !== want) begin
                    n_fail++;
                    $display("FAIL bp_drain[%0d]: got=%h required=%h (data,carry,zero,sel,tag)",
                             r, got, want);
                end
                r++;
            end
        end
        n_cmp++;
        if (r != DEPTH + 1) begin
            n_fail++;
            $display("FAIL bp_drain_count: got %0d required %0d", r, DEPTH + 1);
        end
    endtask

    task automatic test_tag_wrap;
        res_t got, want;
        logic acc, vld, took, have;
        int k = 0;
        int r = 0;
        do_reset();
        for (int i = 0; i < 30; i++) begin
            tick(k < 20, 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 1'b1,
                 acc, vld, took, got, want, have);
            if (acc) k++;
            if (took) begin
                n_cmp++;
                if (!have || got !== want || got.tag !== TAG_W'(r % 16)) begin
                    n_fail++;
                    $display("FAIL tag_wrap[%0d]: tag=%0d data=%h, required tag=%0d data=%h",
                             r, got.tag, got.data, r % 16, want.data);
                end
                r++;
            end
        end
        n_cmp++;
        if (r != 20) begin
            n_fail++;
            $display("FAIL tag_wrap_count: got %0d required 20", r);
        end
    endtask

    task automatic test_random;
        res_t got, want;
        logic acc, vld, took, have;
        for (int i = 0; i < 400; i++) begin
            tick($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom),
                 $urandom_range(0, 2) != 0, acc, vld, took, got, want, have);
            if (took) begin
                n_cmp++;
                if (!have || got !== want) begin
                    n_fail++;
                    $display("FAIL random[%0d]: got=%h required=%h have=%b (data,carry,zero,sel,tag)",
                             i, got, want, have);
                end
            end
        end
        for (int i = 0; i < 3 * DEPTH; i++) begin
            tick(1'b0, 3'd0, 8'd0, 8'd0, 1'b1, acc, vld, took, got, want, have);
            if (took) begin
                n_cmp++;
                if (!have || got !== want) begin
                    n_fail++;
                    $display("FAIL random_drain: got=%h required=%h have=%b", got, want, have);
                end
            end
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL random_leftover: %0d results never appeared, required 0", exp_q.size());
        end
    endtask

    task automatic test_reset_mid;
        res_t got, want;
        logic acc, vld, took, have;
        int r = 0;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 1'b0,
                 acc, vld, took, got, want, have);
        end
        @(negedge clk);
        n_cmp++;
        if (bus.out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_pre_valid: got %b required 1", bus.out_valid);
        end
        rst           = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_sel    = SEL_OR;
        bus.in_a      = 8'h12;
        bus.in_b      = 8'h34;
        bus.out_ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 8'h00 || bus.out_carry !== 1'b0
            || bus.out_sel !== 3'b000 || bus.out_tag !== TAG_W'(0) || bus.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset: valid=%b data=%h carry=%b sel=%b tag=%0d in_ready=%b, required all 0",
                     bus.out_valid, bus.out_data, bus.out_carry, bus.out_sel, bus.out_tag, bus.in_ready);
        end
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        exp_q.delete();
        n_acc = 0;
        tick(1'b1, SEL_XOR, 8'h0F, 8'hF0, 1'b1, acc, vld, took, got, want, have);
        for (int i = 0; i < 8; i++) begin
            tick(1'b0, 3'd0, 8'd0, 8'd0, 1'b1, acc, vld, took, got, want, have);
            if (took) begin
                n_cmp++;
                if (!have || got !== want || got.tag !== TAG_W'(0) || got.data !== 8'hFF) begin
                    n_fail++;
                    $display("FAIL mid_after: data=%h tag=%0d have=%b, required data=ff tag=0 have=1",
                             got.data, got.tag, have);
                end
                r++;
            end
        end
        n_cmp++;
        if (r != 1) begin
            n_fail++;
            $display("FAIL mid_after_count: got %0d results required 1", r);
        end
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_sel    = SEL_ADD;
        bus.in_a      = 8'h11;
        bus.in_b      = 8'h22;
        bus.out_ready = 1'b1;
        n_acc         = 0;
        test_reset();
        test_add_carry();
        test_sub();
        test_back_to_back();
        test_backpressure();
        test_tag_wrap();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "timeout");
    end

endmodule
